pipelined_adder_n: RTL and testbench
====================================

PIPELINED_ADDER_N -- requirements
Module: pipelined_adder_N

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline depth; N SHALL be an integer multiple of STAGES, with slice width W = N/STAGES.
REQ-003 i_Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_nReset  input  1  asynchronous, active-low reset.
REQ-005 i_Valid  input  1  upstream operand valid.
REQ-006 o_Ready  output  1  block accepts operands this cycle.
REQ-007 i_A  input  N  operand A.
REQ-008 i_B  input  N  operand B.
REQ-009 i_CarryIn  input  1  carry into bit 0 for add.
REQ-010 i_Subtract  input  1  1 selects A-B, 0 selects A+B+i_CarryIn.
REQ-011 o_Valid  output  1  result valid.
REQ-012 i_Ready  input  1  downstream accepts result.
REQ-013 o_S  output  N  sum or difference.
REQ-014 o_CarryOut  output  1  carry out of bit N-1; for subtract, 1 means no borrow.

Function
REQ-015 Add SHALL compute {o_CarryOut,o_S} = A + B + i_CarryIn; subtract SHALL compute A + ~B + 1, ignoring i_CarryIn.
REQ-016 Stage k, for k = 0..STAGES-1, SHALL add slice k of A and effective B plus the registered carry from stage k-1, with stage 0 taking the effective carry-in.
REQ-017 Operand slices above the active slice and result slices below it SHALL be registered forward, so that o_S is aligned for one transaction.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance (i_Valid && o_Ready at an edge) to o_Valid, with no stalls.
REQ-019 Throughput SHALL be one transaction per cycle while i_Ready=1.
REQ-020 Stall: when o_Valid=1 && i_Ready=0, every stage SHALL hold its contents and o_S, o_CarryOut and o_Valid SHALL stay stable.
REQ-021 o_Ready SHALL equal i_Ready || !o_Valid, combinationally.
REQ-022 Bubbles (i_Valid=0 at an advancing edge) SHALL propagate as invalid stage entries and SHALL not be presented as results.
REQ-023 Each result SHALL be presented exactly once, in acceptance order; none SHALL be dropped or duplicated.
REQ-024 When STAGES=1, the block SHALL behave as a registered N-bit adder with 1-cycle latency.
REQ-025 Carry wrap-around SHALL be natural modulo 2^N: all-ones + 1 gives o_S=0 and o_CarryOut=1.

Reset
REQ-026 Asserting i_nReset low SHALL immediately clear all stage valid bits, o_Valid, o_S and o_CarryOut to 0, regardless of the clock.
REQ-027 In-flight transactions SHALL be discarded on reset, and no result from them SHALL appear after release.
REQ-028 After release, o_Ready SHALL be 1, and the first accepted operand SHALL appear after exactly STAGES cycles.

Configuration
REQ-029 Macro PIPELINED_ADDER_FLAGS_EN SHALL control the flag outputs.
REQ-030 With PIPELINED_ADDER_FLAGS_EN defined, the block SHALL add outputs o_Overflow (1 bit) and o_Zero (1 bit), aligned with o_S.
REQ-031 o_Overflow SHALL be the carry into bit N-1 XOR o_CarryOut.
REQ-032 o_Zero SHALL be 1 when o_S is 0.
REQ-033 Both flags SHALL reset to 0 and SHALL hold during a stall.
REQ-034 Without the macro, o_Overflow and o_Zero SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=32, STAGES=4)
REQ-035 Add A=0xFFFF_FFFF, B=0x1, CarryIn=0 -> after 4 cycles, o_S=0x0, o_CarryOut=1, o_Zero=1, o_Overflow=0.
REQ-036 Subtract A=0x8000_0000, B=0x1 -> o_S=0x7FFF_FFFF, o_CarryOut=1, o_Overflow=1.
REQ-037 Carry across every slice: add A=0x00FF_FFFF, B=0x1, CarryIn=0 -> o_S=0x0100_0000, o_CarryOut=0; then add A=0x0, B=0x0, CarryIn=1 -> o_S=0x1.
REQ-038 Back-to-back stream of 8 operand pairs with i_Ready=1 -> 8 results in order on consecutive cycles, the first 4 cycles after the first acceptance.
REQ-039 With 4 transactions in flight, hold i_Ready=0 for 3 cycles -> o_S and o_Valid stable, o_Ready=0; on release, the remaining results flow with none lost.
REQ-040 Assert i_nReset low for 1 cycle mid-stream with 3 transactions in flight -> o_Valid=0 at once; no stale results after release; a new operand yields its result 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_adder_n_if.sv
// Operand/result handshake bundle for pipelined_adder_n.
// PIPELINED_ADDER_FLAGS_EN adds the o_Overflow / o_Zero result flags.
interface pipelined_adder_n_if #(
    parameter int N = 32
);
    logic         i_Valid;
    logic         o_Ready;
    logic [N-1:0] i_A;
    logic [N-1:0] i_B;
    logic         i_CarryIn;
    logic         i_Subtract;
    logic         o_Valid;
    logic         i_Ready;
    logic [N-1:0] o_S;
    logic         o_CarryOut;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic         o_Overflow;
    logic         o_Zero;

    modport master (
        output i_Valid, i_A, i_B, i_CarryIn, i_Subtract, i_Ready,
        input  o_Ready, o_Valid, o_S, o_CarryOut, o_Overflow, o_Zero
    );
    modport slave (
        input  i_Valid, i_A, i_B, i_CarryIn, i_Subtract, i_Ready,
        output o_Ready, o_Valid, o_S, o_CarryOut, o_Overflow, o_Zero
    );
`else
    modport master (
        output i_Valid, i_A, i_B, i_CarryIn, i_Subtract, i_Ready,
        input  o_Ready, o_Valid, o_S, o_CarryOut
    );
    modport slave (
        input  i_Valid, i_A, i_B, i_CarryIn, i_Subtract, i_Ready,
        output o_Ready, o_Valid, o_S, o_CarryOut
    );
`endif
endinterface

// File: rtl/pipelined_adder_n.sv
// Pipelined N-bit adder/subtractor: one W = N/STAGES bit slice per stage,
// ripple carry registered between stages, global stall on output backpressure.
// Optional macro PIPELINED_ADDER_FLAGS_EN adds o_Overflow / o_Zero outputs.
module pipelined_adder_n #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input logic             i_Clock,
    input logic             i_nReset,
    pipelined_adder_n_if.slave bus
);
    // N must be a multiple of STAGES; each stage handles W bits.
    localparam int W = N / STAGES;

    logic              adv;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [N-1:0]      b_eff;
    logic              c_eff;

    // The whole pipe moves together; it only freezes when a result is
    // waiting and downstream refuses it.
    assign vld_pipe    = {vld_q, bus.i_Valid};
    assign adv         = bus.i_Ready || !vld_q[STAGES];
    assign bus.o_Ready = adv;
    assign bus.o_Valid = vld_q[STAGES];

    // Subtract is A + ~B + 1; carry-in is ignored in that mode.
    assign b_eff = bus.i_Subtract ? ~bus.i_B : bus.i_B;
    assign c_eff = bus.i_Subtract | bus.i_CarryIn;

    // Valid shift register; bubbles travel as zero entries.
    always_ff @(posedge i_Clock or negedge i_nReset) begin
        if (!i_nReset)
            vld_q <= '0;
        else if (adv)
            vld_q <= vld_pipe[STAGES-1:0];
    end

    // Stage k sees the not-yet-added operand bits (low W bits are its slice)
    // and the result bits already produced; it appends its slice on top.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [N-k*W-1:0]     a_in, b_in;
        logic                 c_in;
        logic [W:0]           s;
        logic [(k+1)*W-1:0]   r_nxt;
        logic [(k+1)*W-1:0]   r_q;
        logic                 c_q;

        if (k == 0) begin : g_src
            assign a_in  = bus.i_A;
            assign b_in  = b_eff;
            assign c_in  = c_eff;
            assign r_nxt = s[W-1:0];
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_fwd.a_q;
            assign b_in  = g_stg[k-1].g_fwd.b_q;
            assign c_in  = g_stg[k-1].c_q;
            assign r_nxt = {s[W-1:0], g_stg[k-1].r_q};
        end

        assign s = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        // Slice sum, accumulated lower result and carry into the next slice.
        always_ff @(posedge i_Clock or negedge i_nReset) begin
            if (!i_nReset) begin
                r_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                r_q <= r_nxt;
                c_q <= s[W];
            end
        end

        if (k < STAGES-1) begin : g_fwd
            logic [N-(k+1)*W-1:0] a_q, b_q;

            // Carry the untouched upper operand slices along with the result.
            always_ff @(posedge i_Clock or negedge i_nReset) begin
                if (!i_nReset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[N-k*W-1:W];
                    b_q <= b_in[N-k*W-1:W];
                end
            end
        end
    end

    assign bus.o_S        = g_stg[STAGES-1].r_q;
    assign bus.o_CarryOut = g_stg[STAGES-1].c_q;

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic ovf_q, zero_q;
    logic c_msb;

    // Carry into bit N-1 recovered from the top bit of the last slice.
    assign c_msb = g_stg[STAGES-1].s[W-1] ^ g_stg[STAGES-1].a_in[W-1]
                 ^ g_stg[STAGES-1].b_in[W-1];

    // Flags are registered alongside the final slice so they track o_S.
    always_ff @(posedge i_Clock or negedge i_nReset) begin
        if (!i_nReset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= c_msb ^ g_stg[STAGES-1].s[W];
            zero_q <= ~|g_stg[STAGES-1].r_nxt;
        end
    end

    assign bus.o_Overflow = ovf_q;
    assign bus.o_Zero     = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed bench for pipelined_adder_n (N=32, STAGES=4).
// Define PIPELINED_ADDER_FLAGS_EN to also check o_Overflow / o_Zero.
module tb_pipelined_adder_n;
    logic clk;
    logic rst_n;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    pipelined_adder_n_if #(.N(32)) bus ();

    pipelined_adder_n #(.N(32), .STAGES(4)) dut (
        .i_Clock (clk),
        .i_nReset(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic sb, input logic v);
        bus.i_A        = a;
        bus.i_B        = b;
        bus.i_CarryIn  = ci;
        bus.i_Subtract = sb;
        bus.i_Valid    = v;
    endtask

    // One isolated transaction; result must appear on the 4th edge counting
    // the accepting edge, and not before.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        drive(a, b, ci, sb, 1'b1);
        step();
        bus.i_Valid = 1'b0;
        step();
        step();
        check({tag, "_early"}, 64'(bus.o_Valid), 64'(1'b0));
        step();
        check({tag, "_vld"}, 64'(bus.o_Valid), 64'(1'b1));
        check({tag, "_s"}, 64'(bus.o_S), 64'(es));
        check({tag, "_co"}, 64'(bus.o_CarryOut), 64'(ec));
`ifdef PIPELINED_ADDER_FLAGS_EN
        check({tag, "_ovf"}, 64'(bus.o_Overflow), 64'(eo));
        check({tag, "_zero"}, 64'(bus.o_Zero), 64'(ez));
`else
        if (eo === 1'bx || ez === 1'bx) $display("note: flag expectation undefined for %s", tag);
`endif
    endtask

    logic [31:0] st_a [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678,
                              32'h0000_FFFF, 32'hAAAA_AAAA, 32'h8000_0000, 32'h00FF_00FF};
    logic [31:0] st_b [8] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h1111_1111,
                              32'h0000_0001, 32'h5555_5555, 32'h8000_0000, 32'hFF00_FF01};
    logic [31:0] st_s [8] = '{32'h0000_0002, 32'h0000_0001, 32'h8000_0000, 32'h2345_6789,
                              32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    logic        st_c [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] sl_a [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] sl_s [4] = '{32'd9, 32'd19, 32'd29, 32'd39};

    initial begin
        logic seen;
        rst_n       = 1'b0;
        bus.i_Ready = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_ovalid", 64'(bus.o_Valid), 64'(1'b0));
        check("rst_os", 64'(bus.o_S), 64'(32'h0));
        check("rst_co", 64'(bus.o_CarryOut), 64'(1'b0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_ordy", 64'(bus.o_Ready), 64'(1'b1));

        // Directed single transactions: tag, A, B, cin, sub, S, CO, OVF, ZERO
        run_one("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_ov", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("ripple", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        run_one("cin",    32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_one("borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("neg_ov", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        run_one("add_ci", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        run_one("sub_ci", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream of 8
        for (int k = 0; k < 8; k++) begin
            drive(st_a[k], st_b[k], 1'b0, 1'b0, 1'b1);
            step();
            if (k == 2) check("str_early", 64'(bus.o_Valid), 64'(1'b0));
            if (k >= 3) begin
                check($sformatf("str%0d_vld", k-3), 64'(bus.o_Valid), 64'(1'b1));
                check($sformatf("str%0d_s", k-3), 64'(bus.o_S), 64'(st_s[k-3]));
                check($sformatf("str%0d_co", k-3), 64'(bus.o_CarryOut), 64'(st_c[k-3]));
            end
        end
        bus.i_Valid = 1'b0;
        for (int j = 5; j < 8; j++) begin
            step();
            check($sformatf("str%0d_vld", j), 64'(bus.o_Valid), 64'(1'b1));
            check($sformatf("str%0d_s", j), 64'(bus.o_S), 64'(st_s[j]));
            check($sformatf("str%0d_co", j), 64'(bus.o_CarryOut), 64'(st_c[j]));
        end
        step();
        check("str_drain", 64'(bus.o_Valid), 64'(1'b0));

        // Stall with four in flight
        for (int k = 0; k < 4; k++) begin
            drive(sl_a[k], 32'd1, 1'b0, 1'b1, 1'b1);
            step();
        end
        bus.i_Valid = 1'b0;
        bus.i_Ready = 1'b0;
        #1;
        check("stl_ordy", 64'(bus.o_Ready), 64'(1'b0));
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("stl_hold%0d_vld", j), 64'(bus.o_Valid), 64'(1'b1));
            check($sformatf("stl_hold%0d_s", j), 64'(bus.o_S), 64'(sl_s[0]));
            check($sformatf("stl_hold%0d_co", j), 64'(bus.o_CarryOut), 64'(1'b1));
            check($sformatf("stl_hold%0d_rdy", j), 64'(bus.o_Ready), 64'(1'b0));
        end
        bus.i_Ready = 1'b1;
        #1;
        check("stl_rel_rdy", 64'(bus.o_Ready), 64'(1'b1));
        for (int j = 1; j < 4; j++) begin
            step();
            check($sformatf("stl%0d_vld", j), 64'(bus.o_Valid), 64'(1'b1));
            check($sformatf("stl%0d_s", j), 64'(bus.o_S), 64'(sl_s[j]));
        end
        step();
        check("stl_drain", 64'(bus.o_Valid), 64'(1'b0));

        // Reset mid-stream
        for (int k = 0; k < 4; k++) begin
            drive(32'h100 + 32'(k), 32'h1, 1'b0, 1'b0, 1'b1);
            step();
        end
        bus.i_Valid = 1'b0;
        check("mr_pre_s", 64'(bus.o_S), 64'(32'h101));
        rst_n = 1'b0;
        #1;
        check("mr_vld", 64'(bus.o_Valid), 64'(1'b0));
        check("mr_s", 64'(bus.o_S), 64'(32'h0));
        check("mr_co", 64'(bus.o_CarryOut), 64'(1'b0));
        step();
        rst_n = 1'b1;
        #1;
        check("mr_ordy", 64'(bus.o_Ready), 64'(1'b1));
        seen = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            seen = seen | bus.o_Valid;
        end
        check("mr_stale", 64'(seen), 64'(1'b0));
        run_one("mr_new", 32'h3, 32'h4, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
